dmem_arbiter: RTL

//   Shares the single-port data memory (DMEM) between the CPU load/store port
//   and a debug/DMA port. Selects one requester per cycle and drives the DMEM

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU load/store port and
//   the debug/DMA port. One requester is granted per cycle; the grant (ack)
//   is combinational in the request cycle and the access happens in that
//   same cycle. Read data is registered and returned one cycle after the
//   grant. Word addresses at or beyond DEPTH_WORDS are rejected with an
//   error response and never written.
//
//   Optional feature: define DMEM_ARB_RR_EN to alternate the winner
//   (round-robin via last_winner) when both ports request and no override
//   applies. Undefined: fixed CPU > DBG priority with the starvation guard.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (held until cpu_ack)
//   cpu_ack/rvalid/err         grant pulse, load/error response next cycle
//   dbg_req/we/addr/wdata      debug/DMA request (held until dbg_ack)
//   dbg_lock                   keep debug granted while it holds a grant
//   dbg_ack/rvalid/err         debug grant pulse and response
//   rdata                      registered read data shared by both ports
//   mem_addr/we/wdata          to dmem
//   mem_rdata                  from dmem (combinational read)
//
// state   | meaning
// IDLE    | no grant in the previous cycle
// CPU_OWN | CPU was granted in the previous cycle
// DBG_OWN | debug was granted in the previous cycle (lock keeps it there)

module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64,
  parameter int MAX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_ack,
  output logic        dbg_rvalid,
  output logic        dbg_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, CPU_OWN, DBG_OWN} state_t;

  state_t            state;
  logic              last_dbg;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cpu_rvalid_q, cpu_err_q, dbg_rvalid_q, dbg_err_q;

  logic cpu_in_range, dbg_in_range;
  logic dbg_force, rr_dbg;
  logic grant_cpu, grant_dbg;
  logic sel_in_range;

  assign cpu_in_range = cpu_addr[31:2] < 30'(DEPTH_WORDS);
  assign dbg_in_range = dbg_addr[31:2] < 30'(DEPTH_WORDS);

  // Debug overrides CPU priority when starved or when holding a locked burst.
  assign dbg_force = (wait_cnt == WAIT_W'(MAX_WAIT)) || (state == DBG_OWN && dbg_lock);

`ifdef DMEM_ARB_RR_EN
  assign rr_dbg = !last_dbg;
`else
  assign rr_dbg = 1'b0;
`endif

  // No grants while in reset, so nothing is written during the reset cycle.
  assign grant_dbg = !reset && dbg_req && (!cpu_req || dbg_force || rr_dbg);
  assign grant_cpu = !reset && cpu_req && !grant_dbg;

  assign cpu_ack = grant_cpu;
  assign dbg_ack = grant_dbg;

  always_comb begin
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_we       = 1'b0;
    sel_in_range = 1'b0;
    if (grant_cpu) begin
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      mem_we       = cpu_we && cpu_in_range;
      sel_in_range = cpu_in_range;
    end else if (grant_dbg) begin
      mem_addr     = dbg_addr;
      mem_wdata    = dbg_wdata;
      mem_we       = dbg_we && dbg_in_range;
      sel_in_range = dbg_in_range;
    end
  end

  // Responses are masked during reset so a pending rvalid never leaks out.
  assign cpu_rvalid = cpu_rvalid_q && !reset;
  assign cpu_err    = cpu_err_q    && !reset;
  assign dbg_rvalid = dbg_rvalid_q && !reset;
  assign dbg_err    = dbg_err_q    && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_dbg     <= 1'b1;
      wait_cnt     <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      rdata        <= 32'd0;
    end else begin
      if (grant_dbg)      state <= DBG_OWN;
      else if (grant_cpu) state <= CPU_OWN;
      else                state <= IDLE;

      if (grant_cpu || grant_dbg) last_dbg <= grant_dbg;

      if (!dbg_req || grant_dbg)              wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;

      // Loads and all out-of-range accesses respond; in-range stores do not.
      cpu_rvalid_q <= grant_cpu && (!cpu_we || !cpu_in_range);
      cpu_err_q    <= grant_cpu && !cpu_in_range;
      dbg_rvalid_q <= grant_dbg && (!dbg_we || !dbg_in_range);
      dbg_err_q    <= grant_dbg && !dbg_in_range;

      if (grant_cpu || grant_dbg) rdata <= sel_in_range ? mem_rdata : 32'd0;
    end
  end

endmodule
